// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: turns one valid/ready command into one non-pipelined
// NONSEQ transfer and reports read data, error status and data-phase wait count.
module ahb_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAIT_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WAIT_W-1:0] rsp_waits,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HRESP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [WAIT_W-1:0]   rsp_waits_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic [1:0]          htrans_q;
    logic                hwrite_q;
    logic [2:0]          hsize_q;
    logic [DATA_W-1:0]   hwdata_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAIT_W-1:0]   waits_cnt_q;
    logic [WAIT_W-1:0]   waits_cnt_d;
    logic                cmd_bad;

    // Sizes above a word, or addresses not aligned to the size, never reach the bus.
    always_comb begin
        cmd_bad = 1'b0;
        case (cmd_size)
            3'd0:    cmd_bad = 1'b0;
            3'd1:    cmd_bad = cmd_addr[0];
            3'd2:    cmd_bad = |cmd_addr[1:0];
            default: cmd_bad = 1'b1;
        endcase
    end

    assign waits_cnt_d = (&waits_cnt_q) ? waits_cnt_q : waits_cnt_q + WAIT_W'(1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_waits_q <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            waits_cnt_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_bad) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_waits_q <= '0;
                        end else begin
                            state_q  <= S_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= cmd_addr;
                            hwrite_q <= cmd_write;
                            hsize_q  <= cmd_size;
                            wdata_q  <= cmd_wdata;
                        end
                    end
                end
                S_ADDR: begin
                    // A low HREADY here belongs to the previous slave's data phase.
                    if (HREADY) begin
                        state_q     <= S_DATA;
                        htrans_q    <= HTRANS_IDLE;
                        hwdata_q    <= hwrite_q ? wdata_q : '0;
                        waits_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (!HREADY) begin
                        waits_cnt_q <= waits_cnt_d;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= HRESP;
                        rsp_rdata_q <= (!hwrite_q && !HRESP) ? HRDATA : '0;
                        rsp_waits_q <= waits_cnt_q;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    htrans_q    <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_waits = rsp_waits_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: a transaction-level timeline model predicts every output for
// every cycle; a second instance with a 2-bit wait counter exercises saturation.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;

    logic        cmd_ready, rsp_valid, rsp_err, HWRITE;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [7:0]  rsp_waits;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_HWRITE;
    logic [31:0] b_rsp_rdata, b_HADDR, b_HWDATA;
    logic [1:0]  b_rsp_waits, b_HTRANS;
    logic [2:0]  b_HSIZE;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .WAIT_W(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_waits(rsp_waits),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .WAIT_W(2)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .rsp_waits(b_rsp_waits),
        .HADDR(b_HADDR), .HTRANS(b_HTRANS), .HWRITE(b_HWRITE), .HSIZE(b_HSIZE), .HWDATA(b_HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  htrans;
        bit          chk_addr;
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        bit          chk_wdata;
        logic [31:0] hwdata;
        logic        cmd_ready;
        logic        rsp_valid;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  waits;
        logic [1:0]  waits_b;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    // Response fields the DUT must be holding (last reported response).
    logic [31:0] m_rdata;
    logic        m_err;
    logic [7:0]  m_waits;
    logic [1:0]  m_waits_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t base();
        exp_t e;
        e.htrans    = 2'b00;
        e.chk_addr  = 1'b0;
        e.haddr     = '0;
        e.hwrite    = 1'b0;
        e.hsize     = 3'd0;
        e.chk_wdata = 1'b0;
        e.hwdata    = '0;
        e.cmd_ready = 1'b0;
        e.rsp_valid = 1'b0;
        e.rdata     = m_rdata;
        e.err       = m_err;
        e.waits     = m_waits;
        e.waits_b   = m_waits_b;
        return e;
    endfunction

    // Single compare process: one expected record per cycle, checked mid-cycle.
    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("htrans", 64'(HTRANS), 64'(e.htrans));
            check("cmd_ready", 64'(cmd_ready), 64'(e.cmd_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(e.rsp_valid));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_waits", 64'(rsp_waits), 64'(e.waits));
            check("b_rsp_valid", 64'(b_rsp_valid), 64'(e.rsp_valid));
            check("b_rsp_waits", 64'(b_rsp_waits), 64'(e.waits_b));
            check("b_htrans", 64'(b_HTRANS), 64'(e.htrans));
            if (e.chk_addr) begin
                check("haddr", 64'(HADDR), 64'(e.haddr));
                check("hwrite", 64'(HWRITE), 64'(e.hwrite));
                check("hsize", 64'(HSIZE), 64'(e.hsize));
            end
            if (e.chk_wdata) begin
                check("hwdata", 64'(HWDATA), 64'(e.hwdata));
                check("b_hwdata", 64'(b_HWDATA), 64'(e.hwdata));
            end
        end
    end

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge HCLK);
        #1;
    endtask

    task automatic noise_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_size  = 3'($urandom);
        cmd_wdata = $urandom;
        HRDATA    = $urandom;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        HRESET = 1'b1;
        m_rdata = '0; m_err = 1'b0; m_waits = '0; m_waits_b = '0;
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'($urandom);
            noise_cmd();
            HREADY = 1'($urandom);
            HRESP  = 1'b0;
            e = base();
            e.cmd_ready = 1'b1;
            e.chk_addr  = 1'b1;
            e.chk_wdata = 1'b1;
            cyc(e);
        end
        HRESET = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            noise_cmd();
            HREADY = 1'($urandom);
            HRESP  = 1'b0;
            e = base();
            e.cmd_ready = 1'b1;
            cyc(e);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input int stall, input int waits,
                        input bit err, input logic [31:0] rd, input bit rst_mid);
        exp_t e, ed;
        bit   bad;
        bad = (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
        $display("xfer %s addr=0x%08h size=%0d wdata=0x%08h stall=%0d waits=%0d err=%0d rst=%0d bad=%0d",
                 w ? "WR" : "RD", a, s, wd, stall, waits, err, rst_mid, bad);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = wd;
        HREADY = 1'($urandom); HRESP = 1'b0; HRDATA = $urandom;
        if (bad) begin
            m_rdata = '0; m_err = 1'b1; m_waits = '0; m_waits_b = '0;
            e = base();
            e.rsp_valid = 1'b1;
            cyc(e);
            cmd_valid = 1'($urandom);
            noise_cmd();
            e = base();
            e.cmd_ready = 1'b1;
            cyc(e);
            cmd_valid = 1'b0;
            return;
        end
        e = base();
        e.htrans = 2'b10; e.chk_addr = 1'b1; e.haddr = a; e.hwrite = w; e.hsize = s;
        cyc(e);
        cmd_valid = 1'($urandom);
        noise_cmd();
        if (rst_mid) begin
            HREADY = 1'b0;
            cyc(e);
            do_reset(2);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            HREADY = 1'b0;
            cyc(e);
        end
        HREADY = 1'b1;
        ed = base();
        ed.chk_wdata = 1'b1;
        ed.hwdata = w ? wd : 32'h0;
        cyc(ed);
        for (int i = 0; i < waits; i++) begin
            HREADY = 1'b0;
            HRESP  = err && (i == waits - 1);
            HRDATA = $urandom;
            cyc(ed);
        end
        HREADY = 1'b1; HRESP = err; HRDATA = rd;
        m_err     = err;
        m_rdata   = (!w && !err) ? rd : 32'h0;
        m_waits   = (waits > 255) ? 8'hFF : 8'(waits);
        m_waits_b = (waits > 3) ? 2'd3 : 2'(waits);
        e = base();
        e.rsp_valid = 1'b1;
        cyc(e);
        HREADY = 1'($urandom); HRESP = 1'b0; cmd_valid = 1'($urandom);
        noise_cmd();
        e = base();
        e.cmd_ready = 1'b1;
        cyc(e);
        cmd_valid = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        noise_cmd();
        do_reset(2);
        check("pin_reset_ready", 64'(cmd_ready), 64'd1);
        idle(2);

        xfer(1'b1, 32'h10, 3'd2, 32'h1234, 0, 0, 1'b0, 32'h0, 1'b1);
        check("pin_rst_htrans", 64'(HTRANS), 64'd0);
        check("pin_rst_ready", 64'(cmd_ready), 64'd1);
        idle(2);

        xfer(1'b1, 32'h04, 3'd2, 32'h0001, 0, 0, 1'b0, 32'h0, 1'b0);
        check("pin_wr_err", 64'(rsp_err), 64'd0);
        check("pin_wr_waits", 64'(rsp_waits), 64'd0);

        xfer(1'b0, 32'h00, 3'd2, 32'h0, 0, 3, 1'b0, 32'h0000A5A5, 1'b0);
        check("pin_rd_rdata", 64'(rsp_rdata), 64'h0000A5A5);
        check("pin_rd_waits", 64'(rsp_waits), 64'd3);

        xfer(1'b0, 32'h08, 3'd2, 32'h0, 0, 1, 1'b1, 32'hDEAD, 1'b0);
        check("pin_rderr_err", 64'(rsp_err), 64'd1);
        check("pin_rderr_rdata", 64'(rsp_rdata), 64'd0);

        xfer(1'b1, 32'h02, 3'd2, 32'h55, 0, 0, 1'b0, 32'h0, 1'b0);
        check("pin_misalign_err", 64'(rsp_err), 64'd1);
        xfer(1'b1, 32'h00, 3'd3, 32'h66, 0, 0, 1'b0, 32'h0, 1'b0);
        check("pin_size3_err", 64'(rsp_err), 64'd1);

        xfer(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 1, 5, 1'b0, 32'h0, 1'b0);
        check("pin_sat_waits", 64'(rsp_waits), 64'd5);
        check("pin_sat_waits_b", 64'(b_rsp_waits), 64'd3);

        xfer(1'b0, 32'h40, 3'd0, 32'h0, 0, 300, 1'b0, 32'h77, 1'b0);
        check("pin_sat8_waits", 64'(rsp_waits), 64'd255);

        for (int t = 0; t < 150; t++) begin
            logic [2:0]  s;
            logic [31:0] a;
            int          wt;
            bit          er;
            s  = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 3'd1) a[0] = 1'b0;
                if (s == 3'd2) a[1:0] = 2'b00;
            end
            er = ($urandom_range(0, 99) < 20);
            wt = $urandom_range(0, 6);
            if (er && wt == 0) wt = 1;
            xfer(1'($urandom), a, s, $urandom, $urandom_range(0, 2), wt, er, $urandom,
                 ($urandom_range(0, 99) < 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(1);
        @(negedge HCLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
